vga_timing: RTL and testbench
=============================

# vga_timing

Display timing generator for the 800x600 VGA output. It produces the pixel coordinate bus, the active-area flag and the sync pulses that every sprite renderer (bars, ball) consumes. It also produces frame, line and vertical-blank markers, so that renderers and custom-instruction logic can commit new coordinates only while nothing is being drawn. There is one instance per design, between the board clock and the renderers and colour mux.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BACK, 64, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 23, vertical back porch (lines)
- SYNC_POL, 1, sync assertion level (1 = positive, 0 = negative); applies to both syncs

Ports:
- clk_in  input  1  board clock, 50 MHz
- i_rst  input  1  asynchronous, active-high reset
- i_pix_stb  input  1  pixel enable; tie to 1 for 50 MHz pixel rate
- o_x  output  11  current column, 0..H_TOTAL-1
- o_y  output  10  current line, 0..V_TOTAL-1
- o_active  output  1  high when o_x < H_ACTIVE and o_y < V_ACTIVE
- o_hs  output  1  horizontal sync
- o_vs  output  1  vertical sync
- o_vblank  output  1  high when o_y >= V_ACTIVE
- o_line  output  1  one-clk_in pulse when o_x becomes 0
- o_frame  output  1  one-clk_in pulse when (o_x, o_y) becomes (0, 0)
- o_animate  output  1  one-clk_in pulse when (o_x, o_y) becomes (0, V_ACTIVE); this is the start of blanking and the safe point to update sprite coordinates

## Operation
- Derived values: H_TOTAL = sum of the four H params (1040); V_TOTAL = sum of the four V params (666).
- A horizontal counter hc and a vertical counter vc advance only on clk_in edges where i_pix_stb = 1.
- hc wraps from H_TOTAL-1 to 0. On that wrap, vc increments, wrapping from V_TOTAL-1 to 0.
- o_x = hc and o_y = vc at all times. Neither is clamped in blanking.
- hsync is asserted (level SYNC_POL) for hc in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. 856..975.
- vsync is asserted for vc in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], i.e. 637..642.
- Reset state parks the counters at (H_TOTAL-1, V_TOTAL-1). The first strobe after release therefore lands on (0,0) and raises o_frame and o_line, so the first frame is complete.
- Reset values: o_x = 1039, o_y = 665, o_active = 0, o_vblank = 1, o_hs = o_vs = !SYNC_POL, o_line = o_frame = o_animate = 0.
- Reset asserted mid-frame returns everything to the reset values immediately (asynchronous). No pulse is emitted during reset.
- When i_pix_stb = 0, all outputs hold and the pulse outputs are 0.

## Timing
- Every output is a flop, computed from the next-state counter values. All outputs therefore change on the same clk_in edge as o_x/o_y and are mutually consistent in every cycle; there is no skew between coordinates and flags.
- Pulses are exactly one clk_in cycle wide, independent of the i_pix_stb rate.
- o_frame and o_line coincide at (0,0).
- o_animate coincides with o_line at (0, V_ACTIVE).
- Frame period = H_TOTAL × V_TOTAL = 692 640 strobes, which gives 72.2 Hz at 50 MHz.
- Counter widths: hc is 11 bits and vc is 10 bits. Elaboration fails if H_TOTAL > 2048 or V_TOTAL > 1024.

## Structure
- Timing constants for 800x600@72 and the derived totals go in the shared package/header vga_defs. Renderers reuse H_ACTIVE and V_ACTIVE from it.
- A single sub-module, wrap_counter, is natural: a parameterised modulo-N counter with enable, async reset-to-N-1 and a wrap strobe. It is instantiated twice, with the horizontal wrap strobe chaining into the vertical enable.
- Sync, active, blank and pulse decode live in the top module.

## Test plan
- Reset, then release with i_pix_stb = 1. The first edge must give o_x = 0, o_y = 0, o_active = 1, o_frame = 1, o_line = 1, o_vblank = 0.
- Run one line. o_hs must be asserted for exactly 120 clocks starting at o_x = 856. o_active must fall at o_x = 800. o_line must pulse again after 1040 clocks.
- Run a full frame. There must be 666 o_line pulses. o_vs must be high for exactly 6 lines starting at o_y = 637. o_animate must pulse once, at (0, 600), together with the o_vblank rise. The next o_frame must come 692 640 clocks after the first.
- Drive i_pix_stb high every 2nd cycle. The frame must take 1 385 280 clocks. Pulses must stay 1 clock wide. Outputs must hold on stalled cycles.
- Assert i_rst at (400, 300) while o_active = 1. The outputs must go to the reset values immediately. After release, the sequence must restart at (0,0) with o_frame.
- Set SYNC_POL = 0. Both syncs must be inverted and idle high in reset; all other outputs must be unchanged.

Source files
------------

// File: rtl/vga_defs.sv
// Shared display timing constants for 800x600@72 (50 MHz pixel clock).
// Renderers import H_ACTIVE / V_ACTIVE from here; the timing generator uses
// the full set plus the coordinate widths.
package vga_defs;

  // Horizontal timing, in pixels.
  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned H_FRONT  = 56;
  localparam int unsigned H_SYNC   = 120;
  localparam int unsigned H_BACK   = 64;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  // Vertical timing, in lines.
  localparam int unsigned V_ACTIVE = 600;
  localparam int unsigned V_FRONT  = 37;
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_BACK   = 23;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Coordinate bus widths.
  localparam int unsigned HC_W = 11;
  localparam int unsigned VC_W = 10;

  // 1 = syncs pulse high, 0 = syncs pulse low.
  localparam bit SYNC_POL = 1'b1;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N counter with enable and a wrap strobe.
// Resets to N-1 so the first enabled edge after reset lands on 0 and wraps.
// Ports:
//   clk_in    clock
//   i_rst     asynchronous active-high reset (count -> N-1)
//   i_en      count enable
//   o_count   registered count, 0..N-1
//   o_next_c  combinational value o_count takes on the next edge
//   o_wrap_c  combinational: this edge takes the count from N-1 to 0
module wrap_counter #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic         clk_in,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next_c,
  output logic         o_wrap_c
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // Refuse to build a counter whose range does not fit its width.
  if (N < 2 || N > (2 ** W)) begin : g_bad_range
    $error("wrap_counter: N=%0d does not fit in W=%0d bits", N, W);
  end

  // Next-count and wrap decode.
  always_comb begin
    o_wrap_c = i_en && (o_count == LAST);
    o_next_c = o_count;
    if (i_en) begin
      o_next_c = o_wrap_c ? '0 : o_count + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_in or posedge i_rst) begin
    if (i_rst) begin
      o_count <= LAST;
    end else begin
      o_count <= o_next_c;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA display timing generator.
// Produces pixel coordinates, active/blank flags, sync pulses and
// line/frame/animate markers. Every output is a flop loaded from the
// next-state counter values, so coordinates and flags never skew.
// Ports:
//   clk_in     board clock
//   i_rst      asynchronous active-high reset
//   i_pix_stb  pixel enable (tie high for one pixel per clock)
//   o_x, o_y   current column / line
//   o_active   inside the visible area
//   o_hs,o_vs  horizontal / vertical sync at level SYNC_POL
//   o_vblank   line is in vertical blanking
//   o_line     one-clock pulse when o_x becomes 0
//   o_frame    one-clock pulse when (o_x,o_y) becomes (0,0)
//   o_animate  one-clock pulse when (o_x,o_y) becomes (0,V_ACTIVE)
module vga_timing
  import vga_defs::*;
#(
  parameter int unsigned H_ACTIVE = vga_defs::H_ACTIVE,
  parameter int unsigned H_FRONT  = vga_defs::H_FRONT,
  parameter int unsigned H_SYNC   = vga_defs::H_SYNC,
  parameter int unsigned H_BACK   = vga_defs::H_BACK,
  parameter int unsigned V_ACTIVE = vga_defs::V_ACTIVE,
  parameter int unsigned V_FRONT  = vga_defs::V_FRONT,
  parameter int unsigned V_SYNC   = vga_defs::V_SYNC,
  parameter int unsigned V_BACK   = vga_defs::V_BACK,
  parameter bit          SYNC_POL = vga_defs::SYNC_POL
) (
  input  logic            clk_in,
  input  logic            i_rst,
  input  logic            i_pix_stb,
  output logic [HC_W-1:0] o_x,
  output logic [VC_W-1:0] o_y,
  output logic            o_active,
  output logic            o_hs,
  output logic            o_vs,
  output logic            o_vblank,
  output logic            o_line,
  output logic            o_frame,
  output logic            o_animate
);

  localparam int unsigned LINE_LEN    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned FRAME_LINES = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [HC_W-1:0] H_ACT_X  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_FIRST = HC_W'(H_ACTIVE + H_FRONT);
  localparam logic [HC_W-1:0] HS_LAST  = HC_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [VC_W-1:0] V_ACT_Y  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_FIRST = VC_W'(V_ACTIVE + V_FRONT);
  localparam logic [VC_W-1:0] VS_LAST  = VC_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  if (LINE_LEN > (2 ** HC_W)) begin : g_bad_h
    $error("vga_timing: H_TOTAL=%0d exceeds %0d-bit column counter", LINE_LEN, HC_W);
  end
  if (FRAME_LINES > (2 ** VC_W)) begin : g_bad_v
    $error("vga_timing: V_TOTAL=%0d exceeds %0d-bit line counter", FRAME_LINES, VC_W);
  end

  logic [HC_W-1:0] hc;
  logic [HC_W-1:0] hc_next;
  logic            h_wrap;
  logic [VC_W-1:0] vc;
  logic [VC_W-1:0] vc_next;
  logic            v_wrap;

  // Column counter; its wrap strobe steps the line counter.
  wrap_counter #(
    .N (LINE_LEN),
    .W (HC_W)
  ) u_hcnt (
    .clk_in   (clk_in),
    .i_rst    (i_rst),
    .i_en     (i_pix_stb),
    .o_count  (hc),
    .o_next_c (hc_next),
    .o_wrap_c (h_wrap)
  );

  wrap_counter #(
    .N (FRAME_LINES),
    .W (VC_W)
  ) u_vcnt (
    .clk_in   (clk_in),
    .i_rst    (i_rst),
    .i_en     (h_wrap),
    .o_count  (vc),
    .o_next_c (vc_next),
    .o_wrap_c (v_wrap)
  );

  assign o_x = hc;
  assign o_y = vc;

  logic active_next;
  logic vblank_next;
  logic hs_on_next;
  logic vs_on_next;
  logic line_next;
  logic frame_next;
  logic animate_next;

  // Flag decode from the coordinates the counters move to on this edge.
  // On stalled cycles the next values equal the current ones, so the
  // level flags hold and the wrap-based pulses stay low.
  always_comb begin
    active_next  = (hc_next < H_ACT_X) && (vc_next < V_ACT_Y);
    vblank_next  = (vc_next >= V_ACT_Y);
    hs_on_next   = (hc_next >= HS_FIRST) && (hc_next <= HS_LAST);
    vs_on_next   = (vc_next >= VS_FIRST) && (vc_next <= VS_LAST);
    line_next    = h_wrap;
    frame_next   = v_wrap;
    animate_next = h_wrap && (vc_next == V_ACT_Y);
  end

  // Output flops; reset values match the parked (H_TOTAL-1, V_TOTAL-1) point.
  always_ff @(posedge clk_in or posedge i_rst) begin
    if (i_rst) begin
      o_active  <= 1'b0;
      o_vblank  <= 1'b1;
      o_hs      <= ~SYNC_POL;
      o_vs      <= ~SYNC_POL;
      o_line    <= 1'b0;
      o_frame   <= 1'b0;
      o_animate <= 1'b0;
    end else begin
      o_active  <= active_next;
      o_vblank  <= vblank_next;
      o_hs      <= hs_on_next ? SYNC_POL : ~SYNC_POL;
      o_vs      <= vs_on_next ? SYNC_POL : ~SYNC_POL;
      o_line    <= line_next;
      o_frame   <= frame_next;
      o_animate <= animate_next;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing: a full-size instance checked over one line and
// a mid-line reset, and a shrunken negative-sync instance checked against a
// cycle model over whole frames, stalled strobes and a mid-frame reset.
module tb_vga_timing;

  logic clk_in;
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Full-size instance, positive sync.
  logic        rst_b, stb_b;
  logic [10:0] bx;
  logic [9:0]  by;
  logic        b_act, b_hs, b_vs, b_vb, b_line, b_frame, b_anim;

  vga_timing u_big (
    .clk_in    (clk_in),
    .i_rst     (rst_b),
    .i_pix_stb (stb_b),
    .o_x       (bx),
    .o_y       (by),
    .o_active  (b_act),
    .o_hs      (b_hs),
    .o_vs      (b_vs),
    .o_vblank  (b_vb),
    .o_line    (b_line),
    .o_frame   (b_frame),
    .o_animate (b_anim)
  );

  // Small instance: 13 columns x 12 lines, negative sync.
  // hs active at x 8..10, vs active at y 7..8, visible 6x5.
  localparam int S_HT = 13;
  localparam int S_VT = 12;
  logic        rst_s, stb_s;
  logic [10:0] sx;
  logic [9:0]  sy;
  logic        s_act, s_hs, s_vs, s_vb, s_line, s_frame, s_anim;

  vga_timing #(
    .H_ACTIVE (6), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_ACTIVE (5), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .SYNC_POL (1'b0)
  ) u_small (
    .clk_in    (clk_in),
    .i_rst     (rst_s),
    .i_pix_stb (stb_s),
    .o_x       (sx),
    .o_y       (sy),
    .o_active  (s_act),
    .o_hs      (s_hs),
    .o_vs      (s_vs),
    .o_vblank  (s_vb),
    .o_line    (s_line),
    .o_frame   (s_frame),
    .o_animate (s_anim)
  );

  // Small-instance reference state.
  int ex, ey;
  logic el, ef, ea;

  function automatic logic [6:0] exp_flags();
    logic act, vb, hs, vs;
    act = (ex < 6) && (ey < 5);
    vb  = (ey >= 5);
    hs  = !((ex >= 8) && (ex <= 10));
    vs  = !((ey >= 7) && (ey <= 8));
    return {act, vb, hs, vs, el, ef, ea};
  endfunction

  // One clock on the small instance: drive strobe, advance model, compare.
  task automatic step_small(input logic stb);
    stb_s = stb;
    @(posedge clk_in);
    el = 1'b0; ef = 1'b0; ea = 1'b0;
    if (stb) begin
      if (ex == S_HT - 1) begin
        ex = 0;
        el = 1'b1;
        if (ey == S_VT - 1) begin
          ey = 0;
          ef = 1'b1;
        end else begin
          ey = ey + 1;
        end
        if (ey == 5) ea = 1'b1;
      end else begin
        ex = ex + 1;
      end
    end
    @(negedge clk_in);
    check("s_xy", {sx, sy}, {11'(ex), 10'(ey)});
    check("s_flags", {s_act, s_vb, s_hs, s_vs, s_line, s_frame, s_anim}, exp_flags());
  endtask

  initial begin
    int hs_cnt, hs_first, act_fall, line_at;
    int lines, frames, vs_low, vs_first_y, anim_cnt, anim_y, hs_low;
    int stall_frame_at, stall_lines;
    logic prev_act, prev_vb;

    rst_b = 1'b1; stb_b = 1'b1;
    rst_s = 1'b1; stb_s = 1'b1;
    ex = S_HT - 1; ey = S_VT - 1; el = 1'b0; ef = 1'b0; ea = 1'b0;
    repeat (3) @(negedge clk_in);

    // Reset values, both polarities.
    check("b_rst_x", bx, 1039);
    check("b_rst_y", by, 665);
    check("b_rst_flags", {b_act, b_vb, b_hs, b_vs, b_line, b_frame, b_anim}, 7'b0100000);
    check("s_rst_xy", {sx, sy}, {11'd12, 10'd11});
    check("s_rst_flags", {s_act, s_vb, s_hs, s_vs, s_line, s_frame, s_anim}, 7'b0111000);

    // Release big instance: first edge lands on (0,0).
    rst_b = 1'b0;
    @(negedge clk_in);
    check("b_first_xy", {bx, by}, {11'd0, 10'd0});
    check("b_first_flags", {b_act, b_vb, b_hs, b_vs, b_line, b_frame, b_anim}, 7'b1000110);

    // One line.
    hs_cnt = 0; hs_first = -1; act_fall = -1; line_at = -1; prev_act = b_act;
    for (int i = 1; i <= 1040; i++) begin
      @(negedge clk_in);
      if (b_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(bx);
      end
      if (prev_act && !b_act && act_fall < 0) act_fall = int'(bx);
      if (b_line && line_at < 0) line_at = i;
      prev_act = b_act;
    end
    check("b_hs_width", hs_cnt, 120);
    check("b_hs_start", hs_first, 856);
    check("b_act_fall_x", act_fall, 800);
    check("b_line_period", line_at, 1040);
    check("b_line1_xy", {bx, by}, {11'd0, 10'd1});
    check("b_line1_frame", b_frame, 0);

    // Async reset mid-line while visible.
    repeat (400) @(negedge clk_in);
    check("b_pre_rst_xy", {bx, by}, {11'd400, 10'd1});
    check("b_pre_rst_act", b_act, 1);
    #2 rst_b = 1'b1;
    #1;
    check("b_async_xy", {bx, by}, {11'd1039, 10'd665});
    check("b_async_flags", {b_act, b_vb, b_hs, b_vs, b_line, b_frame, b_anim}, 7'b0100000);
    @(negedge clk_in);
    check("b_in_rst_flags", {b_act, b_vb, b_hs, b_vs, b_line, b_frame, b_anim}, 7'b0100000);
    rst_b = 1'b0;
    @(negedge clk_in);
    check("b_restart_xy", {bx, by}, {11'd0, 10'd0});
    check("b_restart_pulses", {b_line, b_frame, b_anim}, 3'b110);

    // Small instance: release, then one full frame at full rate.
    rst_s = 1'b0;
    step_small(1'b1);
    check("s_first_frame", s_frame, 1);
    lines = 0; frames = 0; vs_low = 0; vs_first_y = -1; anim_cnt = 0; anim_y = -1; hs_low = 0;
    prev_vb = s_vb;
    for (int i = 1; i <= S_HT * S_VT; i++) begin
      step_small(1'b1);
      if (s_line) lines++;
      if (s_frame) frames++;
      if (!s_hs) hs_low++;
      if (!s_vs) begin
        vs_low++;
        if (vs_first_y < 0) vs_first_y = int'(sy);
      end
      if (s_anim) begin
        anim_cnt++;
        anim_y = int'(sy);
        check("s_anim_vb_rise", {prev_vb, s_vb, s_line, 11'(sx)}, {1'b0, 1'b1, 1'b1, 11'd0});
      end
      prev_vb = s_vb;
    end
    check("s_frame_lines", lines, 12);
    check("s_frame_frames", frames, 1);
    check("s_frame_end_frame", s_frame, 1);
    check("s_vs_low_cycles", vs_low, 26);
    check("s_vs_first_y", vs_first_y, 7);
    check("s_hs_low_cycles", hs_low, 36);
    check("s_anim_cnt", anim_cnt, 1);
    check("s_anim_y", anim_y, 5);

    // Half-rate strobe: one frame takes twice the clocks.
    stall_frame_at = -1; stall_lines = 0;
    for (int i = 1; i <= 400 && stall_frame_at < 0; i++) begin
      step_small(logic'(i % 2 == 0));
      if (s_line) stall_lines++;
      if (s_frame) stall_frame_at = i;
    end
    check("s_stall_frame_clocks", stall_frame_at, 312);
    check("s_stall_line_pulse_clocks", stall_lines, 12);
    step_small(1'b0);
    check("s_stall_pulse_width", {s_line, s_frame}, 2'b00);

    // Mid-frame async reset at (3,2) while visible.
    for (int i = 0; i < 29; i++) step_small(1'b1);
    check("s_pre_rst_xy", {sx, sy}, {11'd3, 10'd2});
    check("s_pre_rst_act", s_act, 1);
    #2 rst_s = 1'b1;
    #1;
    check("s_async_xy", {sx, sy}, {11'd12, 10'd11});
    check("s_async_flags", {s_act, s_vb, s_hs, s_vs, s_line, s_frame, s_anim}, 7'b0111000);
    @(negedge clk_in);
    check("s_in_rst_flags", {s_act, s_vb, s_hs, s_vs, s_line, s_frame, s_anim}, 7'b0111000);
    rst_s = 1'b0;
    ex = S_HT - 1; ey = S_VT - 1;
    step_small(1'b1);
    check("s_restart_frame", {s_line, s_frame}, 2'b11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
